spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_master.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 style master that frames each payload word as
// {01, upper nibble, 10, lower nibble}, shifts it out MSB first and unpacks
// the word received on MISO in the same framing.
// Optional build macro SPI_MASTER_FRAME_CHECK_EN adds a check of the received
// marker bits that drives rx_frame_err; without it rx_frame_err is tied low.
// WORD_WIDTH must be even and >= 4; CLK_DIV must be >= 2.
// "release" is a reserved word in SystemVerilog, so that port is release_req.
// dbg_state exposes the FSM state for checkers.
//
// Handshake: a request is taken on the clk edge where start=1 and ready=1.
// tx_word and keep_sel are captured on that edge. ready is 1 only in IDLE
// (after the first edge out of reset) and in HOLD. start while ready=0 and
// release_req outside HOLD have no effect. rx_valid is a one-cycle pulse with
// rx_word (and rx_frame_err) valid in the same cycle; there is no
// back-pressure on the receive side.
module spi_master #(
  parameter int WORD_WIDTH = 8,
  parameter int CLK_DIV    = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] tx_word,
  input  logic                  keep_sel,
  input  logic                  release_req,
  output logic                  ready,
  output logic [WORD_WIDTH-1:0] rx_word,
  output logic                  rx_valid,
  output logic                  rx_frame_err,
  output logic                  spi_SCLK,
  output logic                  spi_SSEL,
  output logic                  spi_MOSI,
  input  logic                  spi_MISO,
  output logic [2:0]            dbg_state
);

  localparam int PACKET_WIDTH = WORD_WIDTH + 4;
  localparam int NIBBLE_WIDTH = WORD_WIDTH / 2;
  // Phase counter covers the longest phase (LEAD / GAP = two half-periods).
  localparam int PH_W  = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(PACKET_WIDTH);

  localparam logic [PH_W-1:0]  PH_HALF_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LONG_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(PACKET_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_LOW  = 3'd2,
    ST_HIGH = 3'd3,
    ST_GAP  = 3'd4,
    ST_HOLD = 3'd5
  } state_t;

  state_t                  r_state;
  logic [PH_W-1:0]         r_phase;
  logic [BIT_W-1:0]        r_bit;
  logic [PACKET_WIDTH-1:0] r_tx;
  logic [PACKET_WIDTH-1:0] r_rx;
  logic                    r_keep;
  logic                    r_ready;
  logic                    r_sclk;
  logic                    r_ssel;
  logic                    r_rx_valid;
  logic [WORD_WIDTH-1:0]   r_rx_word;

  logic                    w_accept;
  logic [PACKET_WIDTH-1:0] w_packet;
  logic [WORD_WIDTH-1:0]   w_rx_word;

  assign w_accept = start && r_ready;

  assign w_packet = {2'b01, tx_word[WORD_WIDTH-1:NIBBLE_WIDTH],
                     2'b10, tx_word[NIBBLE_WIDTH-1:0]};

  // Strip the two marker pairs out of the received packet.
  assign w_rx_word = {r_rx[PACKET_WIDTH-3:PACKET_WIDTH/2],
                      r_rx[PACKET_WIDTH/2-3:0]};

`ifdef SPI_MASTER_FRAME_CHECK_EN
  logic r_frame_err;
  logic w_frame_bad;

  assign w_frame_bad = (r_rx[PACKET_WIDTH-1:PACKET_WIDTH-2] != 2'b01) ||
                       (r_rx[PACKET_WIDTH/2-1:PACKET_WIDTH/2-2] != 2'b10);
  assign rx_frame_err = r_frame_err;
`else
  // Marker bits are received but deliberately not inspected in this build.
  logic w_unused_markers;

  assign w_unused_markers = ^{r_rx[PACKET_WIDTH-1:PACKET_WIDTH-2],
                              r_rx[PACKET_WIDTH/2-1:PACKET_WIDTH/2-2]};
  assign rx_frame_err = 1'b0;
`endif

  // Transfer FSM: framing, SCLK generation, shifting and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_phase    <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_keep     <= 1'b0;
      r_ready    <= 1'b0;
      r_sclk     <= 1'b0;
      r_ssel     <= 1'b1;
      r_rx_valid <= 1'b0;
      r_rx_word  <= '0;
`ifdef SPI_MASTER_FRAME_CHECK_EN
      r_frame_err <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_LEAD;
            r_ready <= 1'b0;
            r_ssel  <= 1'b0;
            r_tx    <= w_packet;
            r_keep  <= keep_sel;
            r_phase <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end

        ST_LEAD: begin
          if (r_phase == PH_LONG_LAST) begin
            r_state <= ST_HIGH;
            r_phase <= '0;
            r_sclk  <= 1'b1;
            r_rx    <= {r_rx[PACKET_WIDTH-2:0], spi_MISO};
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end

        ST_HIGH: begin
          if (r_phase == PH_HALF_LAST) begin
            r_sclk  <= 1'b0;
            r_phase <= '0;
            if (r_bit == BIT_LAST) begin
              // Final fall: packet complete, publish the received word.
              r_rx_valid <= 1'b1;
              r_rx_word  <= w_rx_word;
`ifdef SPI_MASTER_FRAME_CHECK_EN
              r_frame_err <= w_frame_bad;
`endif
              r_tx <= '0;
              if (r_keep) begin
                r_state <= ST_HOLD;
                r_ready <= 1'b1;
              end else begin
                r_state <= ST_GAP;
                r_ssel  <= 1'b1;
              end
            end else begin
              r_state <= ST_LOW;
              r_tx    <= {r_tx[PACKET_WIDTH-2:0], 1'b0};
              r_bit   <= r_bit + BIT_W'(1);
            end
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end

        ST_LOW: begin
          if (r_phase == PH_HALF_LAST) begin
            r_state <= ST_HIGH;
            r_phase <= '0;
            r_sclk  <= 1'b1;
            r_rx    <= {r_rx[PACKET_WIDTH-2:0], spi_MISO};
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end

        ST_GAP: begin
          if (r_phase == PH_LONG_LAST) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_ready <= 1'b1;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end

        ST_HOLD: begin
          // start wins over a simultaneous release; SSEL stays low.
          if (w_accept) begin
            r_state <= ST_LEAD;
            r_ready <= 1'b0;
            r_tx    <= w_packet;
            r_keep  <= keep_sel;
            r_phase <= '0;
            r_bit   <= '0;
          end else if (release_req) begin
            r_state <= ST_GAP;
            r_ready <= 1'b0;
            r_ssel  <= 1'b1;
            r_phase <= '0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_ssel  <= 1'b1;
          r_sclk  <= 1'b0;
          r_tx    <= '0;
          r_phase <= '0;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign rx_word   = r_rx_word;
  assign rx_valid  = r_rx_valid;
  assign spi_SCLK  = r_sclk;
  assign spi_SSEL  = r_ssel;
  assign spi_MOSI  = r_tx[PACKET_WIDTH-1];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master with default parameters.
// A slave model plays back a packet on MISO; a reference model derives the
// expected MOSI packet, rx_word and rx_frame_err from the framing rules.
module tb_spi_master;

  localparam int WW    = 8;
  localparam int CD    = 5;
  localparam int PW    = WW + 4;
  localparam int NW    = WW / 2;
  localparam int CLK_P = 10;
`ifdef SPI_MASTER_FRAME_CHECK_EN
  localparam bit FRAME_CHECK = 1'b1;
`else
  localparam bit FRAME_CHECK = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [WW-1:0] tx_word;
  logic          keep_sel;
  logic          release_req;
  logic          ready;
  logic [WW-1:0] rx_word;
  logic          rx_valid;
  logic          rx_frame_err;
  logic          spi_SCLK;
  logic          spi_SSEL;
  logic          spi_MOSI;
  logic          spi_MISO;
  logic [2:0]    dbg_state;

  spi_master #(.WORD_WIDTH(WW), .CLK_DIV(CD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .tx_word      (tx_word),
    .keep_sel     (keep_sel),
    .release_req  (release_req),
    .ready        (ready),
    .rx_word      (rx_word),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .spi_SCLK     (spi_SCLK),
    .spi_SSEL     (spi_SSEL),
    .spi_MOSI     (spi_MOSI),
    .spi_MISO     (spi_MISO),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #(CLK_P / 2) clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check / counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Packet on the wire: 01, upper nibble, 10, lower nibble.
  function automatic logic [PW-1:0] frame(input logic [WW-1:0] w);
    int hi, lo, p;
    hi = int'(w) / (1 << NW);
    lo = int'(w) % (1 << NW);
    p  = (1 << (PW - 2)) + hi * (1 << (NW + 2)) + 2 * (1 << NW) + lo;
    return PW'(p);
  endfunction

  // Expected {frame_err, rx_word} for a packet the slave sends.
  function automatic logic [WW:0] model_rx(input logic [PW-1:0] s);
    int v, hi, lo;
    bit err;
    v   = int'(s);
    hi  = (v / (1 << (NW + 2))) % (1 << NW);
    lo  = v % (1 << NW);
    err = FRAME_CHECK && (((v / (1 << (PW - 2))) != 1) || (((v / (1 << NW)) % 4) != 2));
    return {err, WW'(hi * (1 << NW) + lo)};
  endfunction

  // ---------------- slave model ----------------
  // Presents bit PW-1 first and advances on each SCLK fall.
  logic [PW-1:0] slave_pkt = '0;
  int            s_idx     = 0;

  initial forever begin
    @(negedge spi_SCLK or negedge reset_n);
    if (!reset_n) s_idx = 0;
    else          s_idx = (s_idx == PW - 1) ? 0 : s_idx + 1;
  end

  always_comb spi_MISO = slave_pkt[PW-1-s_idx];

  // ---------------- monitors ----------------
  logic [PW-1:0] mon_sr = '0;
  int            rise_total = 0;
  time           rise_times[$];
  time           t_ssel_fall = 0;
  time           t_ssel_rise = 0;
  time           t_ready_rise = 0;
  int            ssel_rises = 0;

  initial forever begin
    @(posedge spi_SCLK);
    mon_sr = {mon_sr[PW-2:0], spi_MOSI};
    rise_total++;
    rise_times.push_back($time);
  end

  initial forever begin
    @(negedge spi_SSEL);
    t_ssel_fall = $time;
  end

  initial forever begin
    @(posedge spi_SSEL);
    t_ssel_rise = $time;
    ssel_rises++;
  end

  initial forever begin
    @(posedge ready);
    t_ready_rise = $time;
  end

  // ---------------- scoreboard ----------------
  logic [WW:0]   exp_q[$];
  logic [PW-1:0] exp_mosi_q[$];
  int            rx_cnt = 0;
  int            rise_base = 0;
  logic [WW-1:0] last_rx_word = '0;
  logic [PW-1:0] last_mosi = '0;

  initial forever begin
    logic [WW:0]   e_rx;
    logic [PW-1:0] e_m;
    @(negedge clk);
    if (!reset_n) begin
      rise_base = rise_total;
    end else if (rx_valid) begin
      rx_cnt++;
      last_rx_word = rx_word;
      last_mosi    = mon_sr;
      check("rx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e_rx = exp_q.pop_front();
        e_m  = exp_mosi_q.pop_front();
        check("rx_word", 32'(rx_word), 32'(e_rx[WW-1:0]));
        check("rx_frame_err", 32'(rx_frame_err), 32'(e_rx[WW]));
        check("mosi_packet", 32'(mon_sr), 32'(e_m));
      end
      check("sclk_rises", 32'(rise_total - rise_base), 32'(PW));
      rise_base = rise_total;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(ready), 32'd1);
  endtask

  task automatic do_xfer(input logic [WW-1:0] tx, input logic [PW-1:0] spkt,
                         input logic keep, input logic noise, input logic with_rel);
    int n;
    int rx_before;
    wait_ready();
    slave_pkt = spkt;
    exp_q.push_back(model_rx(spkt));
    exp_mosi_q.push_back(frame(tx));
    rx_before   = rx_cnt;
    tx_word     = tx;
    keep_sel    = keep;
    release_req = with_rel;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    release_req = 1'b0;
    tx_word     = WW'($urandom);
    keep_sel    = 1'($urandom);
    if (noise) begin
      // Stray start / release mid-transfer must be ignored.
      repeat ($urandom_range(2, 80)) @(negedge clk);
      if (!ready) begin
        start       = 1'b1;
        release_req = 1'($urandom);
        tx_word     = WW'($urandom);
        @(negedge clk);
        start       = 1'b0;
        release_req = 1'b0;
      end
    end
    n = 0;
    while (rx_cnt == rx_before && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rx_pulses", 32'(rx_cnt - rx_before), 32'd1);
  endtask

  task automatic do_release();
    @(negedge clk);
    release_req = 1'b1;
    @(negedge clk);
    release_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int            rises0, rise0, rxc0, n, base_r;
    logic          in_hold, was_hold, keep;
    logic [WW-1:0] tx;
    logic [PW-1:0] spkt;

    reset_n = 1'b0; start = 1'b0; tx_word = '0; keep_sel = 1'b0; release_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(spi_SCLK), 32'd0);
    check("rst_ssel", 32'(spi_SSEL), 32'd1);
    check("rst_mosi", 32'(spi_MOSI), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_word", 32'(rx_word), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready_first_edge", 32'(ready), 32'd1);

    // A5 out, slave returns 8'h36 framed as {01,0011,10,0110} = 12'h4E6.
    wait_ready();
    base_r = rise_times.size();
    do_xfer(8'hA5, 12'h4E6, 1'b0, 1'b0, 1'b0);
    check("a5_mosi_bits", 32'(last_mosi), 32'b0110_1010_0101);
    check("a5_rx_word", 32'(last_rx_word), 32'h36);
    check("lead_clks", 32'((rise_times[base_r] - t_ssel_fall) / CLK_P), 32'd10);
    check("sclk_period_clks", 32'((rise_times[base_r+1] - rise_times[base_r]) / CLK_P), 32'd10);
    wait_ready();
    check("a5_ssel_idle", 32'(spi_SSEL), 32'd1);

    // Two held packets then release.
    wait_ready();
    rises0 = ssel_rises;
    do_xfer(8'h00, frame(WW'($urandom)), 1'b1, 1'b0, 1'b0);
    do_xfer(8'h01, frame(WW'($urandom)), 1'b1, 1'b0, 1'b0);
    check("hold_no_ssel_rise", 32'(ssel_rises - rises0), 32'd0);
    check("hold_ssel_low", 32'(spi_SSEL), 32'd0);
    check("hold_ready", 32'(ready), 32'd1);
    check("hold_sclk_low", 32'(spi_SCLK), 32'd0);
    do_release();
    wait_ready();
    check("gap_ssel_rise_once", 32'(ssel_rises - rises0), 32'd1);
    check("gap_ssel_high_clks", 32'((t_ready_rise - t_ssel_rise) / CLK_P), 32'd10);

    // start and release together in HOLD: start wins.
    do_xfer(8'h3C, frame(WW'($urandom)), 1'b1, 1'b0, 1'b0);
    rises0 = ssel_rises;
    do_xfer(8'hC3, frame(WW'($urandom)), 1'b1, 1'b0, 1'b1);
    check("start_wins_no_ssel_rise", 32'(ssel_rises - rises0), 32'd0);
    check("start_wins_ssel_low", 32'(spi_SSEL), 32'd0);
    do_release();

    // Bad markers from the slave.
    do_xfer(8'h5A, 12'hFFF, 1'b0, 1'b0, 1'b0);
    check("ff_rx_word", 32'(last_rx_word), 32'hFF);
    check("ff_frame_err", 32'(rx_frame_err), 32'(FRAME_CHECK));
    wait_ready();
    repeat (20) @(negedge clk);
    check("ff_frame_err_held", 32'(rx_frame_err), 32'(FRAME_CHECK));
    do_xfer(8'h11, frame(8'h77), 1'b0, 1'b0, 1'b0);
    check("frame_err_cleared", 32'(rx_frame_err), 32'd0);

    // Reset after the 5th SCLK rise.
    wait_ready();
    slave_pkt = PW'($urandom);
    rise0 = rise_total;
    rxc0  = rx_cnt;
    tx_word = WW'($urandom); keep_sel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((rise_total - rise0) < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_at_5_rises", 32'(rise_total - rise0), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_ssel", 32'(spi_SSEL), 32'd1);
    check("abort_sclk", 32'(spi_SCLK), 32'd0);
    check("abort_mosi", 32'(spi_MOSI), 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_rx_valid", 32'(rx_valid), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready_after_release", 32'(ready), 32'd1);
    check("abort_no_rx", 32'(rx_cnt - rxc0), 32'd0);

    // Randomized traffic.
    in_hold = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tx   = WW'($urandom);
      keep = ($urandom_range(0, 2) == 0);
      spkt = ($urandom_range(0, 3) == 0) ? PW'($urandom) : frame(WW'($urandom));
      was_hold = in_hold;
      rises0   = ssel_rises;
      do_xfer(tx, spkt, keep, 1'($urandom_range(0, 1)), 1'b0);
      if (was_hold) check("rand_hold_ssel_rises", 32'(ssel_rises - rises0), keep ? 32'd0 : 32'd1);
      in_hold = keep;
      if (keep && $urandom_range(0, 1) == 1) begin
        do_release();
        in_hold = 1'b0;
      end
    end
    if (in_hold) do_release();

    repeat (30) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
